// File: rtl/iter_alu.sv
// ============================================================================
//  Module   : iter_alu
//  Purpose  : Single-issue integer ALU with valid/ready handshakes. Logic ops
//             complete in one cycle; MUL runs a radix-2 shift-add multiplier
//             (one partial product per cycle) and writes back both halves.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_alu #(
  parameter int WIDTH  = 64,
  parameter int NREGS  = 16,
  parameter int LO_REG = 0,
  parameter int HI_REG = 2,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [RW-1:0]    in_dst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_we0,
  output logic [RW-1:0]    out_idx0,
  output logic [WIDTH-1:0] out_data0,
  output logic             out_we1,
  output logic [RW-1:0]    out_idx1,
  output logic [WIDTH-1:0] out_data1,
  output logic             out_fwe,
  output logic             out_zf,
  output logic             out_cf,
  output logic             out_ret
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_RET = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      mul_cnt;
  logic [WIDTH-1:0]   mcand;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // and is shifted out one bit per step as product bits shift in.
  logic [2*WIDTH-1:0] prod;

  logic               accept;
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cf;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_next;

  // A new op may enter when idle, or when the held result drains this cycle.
  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Single-cycle result for the non-multiply opcodes.
  always_comb begin
    add_full = {1'b0, in_a} + {1'b0, in_b};
    alu_res  = '0;
    alu_cf   = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_cf  = add_full[WIDTH];
      end
      OP_SUB: begin
        alu_res = in_a - in_b;
        alu_cf  = (in_a < in_b);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_MOV:  alu_res = in_b;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand, then shift right.
  always_comb begin
    addend    = prod[0] ? mcand : '0;
    step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_next = {step_sum, prod[WIDTH-1:1]};
  end

  // Control FSM plus registered writeback outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mul_cnt   <= '0;
      mcand     <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
      out_we0   <= 1'b0;
      out_idx0  <= '0;
      out_data0 <= '0;
      out_we1   <= 1'b0;
      out_idx1  <= '0;
      out_data1 <= '0;
      out_fwe   <= 1'b0;
      out_zf    <= 1'b0;
      out_cf    <= 1'b0;
      out_ret   <= 1'b0;
    end else if (accept) begin
      if (in_op == OP_MUL) begin
        state     <= S_MUL;
        out_valid <= 1'b0;
        mcand     <= in_a;
        prod      <= {{WIDTH{1'b0}}, in_b};
        mul_cnt   <= '0;
        out_we0   <= 1'b0;
        out_we1   <= 1'b0;
        out_fwe   <= 1'b0;
        out_ret   <= 1'b0;
      end else begin
        state     <= S_DONE;
        out_valid <= 1'b1;
        out_we0   <= (in_op != OP_RET);
        out_idx0  <= in_dst;
        out_data0 <= alu_res;
        out_we1   <= 1'b0;
        out_idx1  <= '0;
        out_data1 <= '0;
        out_fwe   <= (in_op <= OP_XOR);
        out_zf    <= (alu_res == '0);
        out_cf    <= alu_cf;
        out_ret   <= (in_op == OP_RET);
      end
    end else begin
      case (state)
        S_MUL: begin
          prod    <= prod_next;
          mul_cnt <= mul_cnt + CW'(1);
          if (mul_cnt == LAST_STEP) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_we0   <= 1'b1;
            out_idx0  <= RW'(LO_REG);
            out_data0 <= prod_next[WIDTH-1:0];
            out_we1   <= 1'b1;
            out_idx1  <= RW'(HI_REG);
            out_data1 <= prod_next[2*WIDTH-1:WIDTH];
            out_fwe   <= 1'b1;
            out_cf    <= |prod_next[2*WIDTH-1:WIDTH];
            out_zf    <= (prod_next == '0);
            out_ret   <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iter_alu.sv
// ============================================================================
//  Module   : tb_iter_alu
//  Purpose  : Self-checking bench for iter_alu (64-bit and 8-bit instances)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_alu;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [3:0]    in_dst = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_we0, out_we1, out_fwe, out_zf, out_cf, out_ret;
  logic [3:0]    out_idx0, out_idx1;
  logic [W-1:0]  out_data0, out_data1;

  logic          e_reset = 1'b1;
  logic          e_in_valid = 1'b0;
  logic          e_in_ready;
  logic [2:0]    e_in_op = '0;
  logic [3:0]    e_in_dst = '0;
  logic [7:0]    e_in_a = '0;
  logic [7:0]    e_in_b = '0;
  logic          e_out_valid;
  logic          e_out_ready = 1'b1;
  logic          e_we0, e_we1, e_fwe, e_zf, e_cf, e_ret;
  logic [3:0]    e_idx0, e_idx1;
  logic [7:0]    e_data0, e_data1;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(W), .NREGS(16), .LO_REG(0), .HI_REG(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_we0(out_we0), .out_idx0(out_idx0), .out_data0(out_data0),
    .out_we1(out_we1), .out_idx1(out_idx1), .out_data1(out_data1),
    .out_fwe(out_fwe), .out_zf(out_zf), .out_cf(out_cf), .out_ret(out_ret)
  );

  iter_alu #(.WIDTH(8), .NREGS(16), .LO_REG(0), .HI_REG(2)) dut8 (
    .clk(clk), .reset(e_reset), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_op(e_in_op), .in_dst(e_in_dst), .in_a(e_in_a), .in_b(e_in_b),
    .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_we0(e_we0), .out_idx0(e_idx0), .out_data0(e_data0),
    .out_we1(e_we1), .out_idx1(e_idx1), .out_data1(e_data1),
    .out_fwe(e_fwe), .out_zf(e_zf), .out_cf(e_cf), .out_ret(e_ret)
  );

  typedef struct packed {
    logic         we0;
    logic [3:0]   idx0;
    logic [W-1:0] data0;
    logic         we1;
    logic [3:0]   idx1;
    logic [W-1:0] data1;
    logic         fwe;
    logic         zf;
    logic         cf;
    logic         ret;
  } res_t;

  int   checks = 0;
  int   errors = 0;

  // Reference model state: cycles left on an in-flight multiply, whether a
  // result is currently presented, and the expected result contents.
  int   m_wait = 0;
  bit   m_have = 1'b0;
  bit   m_post_rst = 1'b0;
  bit   m_known = 1'b0;
  bit   m_ready = 1'b0;
  res_t m_res = '0;
  res_t m_pend = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic res_t model_op(input logic [2:0] op, input logic [3:0] dst,
                                    input logic [W-1:0] a, input logic [W-1:0] b);
    res_t         r;
    logic [W:0]   s;
    logic [127:0] p;
    r = '0;
    s = {1'b0, a} + {1'b0, b};
    p = {64'd0, a} * {64'd0, b};
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
        r.we0  = 1'b1;
        r.idx0 = dst;
        r.fwe  = 1'b1;
        case (op)
          3'd0: begin r.data0 = s[W-1:0]; r.cf = s[W]; end
          3'd1: begin r.data0 = a - b;    r.cf = (a < b); end
          3'd2: r.data0 = a & b;
          3'd3: r.data0 = a | b;
          default: r.data0 = a ^ b;
        endcase
        r.zf = (r.data0 == 0);
      end
      3'd5: begin r.we0 = 1'b1; r.idx0 = dst; r.data0 = b; end
      3'd6: begin
        r.we0 = 1'b1; r.idx0 = 4'd0; r.data0 = p[63:0];
        r.we1 = 1'b1; r.idx1 = 4'd2; r.data1 = p[127:64];
        r.fwe = 1'b1; r.cf = (p[127:64] != 0); r.zf = (p == 0);
      end
      default: r.ret = 1'b1;
    endcase
    return r;
  endfunction

  // Compare the DUT against the model for the current cycle.
  task automatic compare();
    if (!m_known) return;
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_have);
    if (m_have) begin
      chk("we0", out_we0, m_res.we0);
      if (m_res.we0) begin
        chk("idx0", out_idx0, m_res.idx0);
        chk("data0", out_data0, m_res.data0);
      end
      chk("we1", out_we1, m_res.we1);
      if (m_res.we1) begin
        chk("idx1", out_idx1, m_res.idx1);
        chk("data1", out_data1, m_res.data1);
      end
      chk("fwe", out_fwe, m_res.fwe);
      if (m_res.fwe) begin
        chk("zf", out_zf, m_res.zf);
        chk("cf", out_cf, m_res.cf);
      end
      chk("ret", out_ret, m_res.ret);
    end else if (m_post_rst) begin
      chk("rst_we0", out_we0, 1'b0);
      chk("rst_we1", out_we1, 1'b0);
      chk("rst_fwe", out_fwe, 1'b0);
      chk("rst_ret", out_ret, 1'b0);
      chk("rst_data0", out_data0, '0);
    end
  endtask

  // One clock cycle: drive at negedge, check, advance the model at posedge,
  // and return at the following negedge with outputs settled.
  task automatic cycle(input bit v, input logic [2:0] op, input logic [3:0] dst,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ordy, input bit rst);
    bit acc;
    in_valid = v; in_op = op; in_dst = dst; in_a = a; in_b = b;
    out_ready = ordy; reset = rst;
    m_ready = (m_wait == 0) && (!m_have || ordy);
    #1;
    compare();
    acc = v && m_ready;
    @(posedge clk);
    if (rst) begin
      m_have = 1'b0; m_wait = 0; m_post_rst = 1'b1; m_known = 1'b1;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin m_have = 1'b1; m_res = m_pend; end
    end else if (acc) begin
      m_post_rst = 1'b0;
      if (op == 3'd6) begin
        m_pend = model_op(op, dst, a, b); m_wait = W; m_have = 1'b0;
      end else begin
        m_res = model_op(op, dst, a, b); m_have = 1'b1;
      end
    end else if (m_have && ordy) begin
      m_have = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [2:0]  rop;
    logic [7:0]  ea, eb;
    logic [15:0] ep;
    int          r;

    @(negedge clk);
    cycle(0, 3'd0, 4'd0, '0, '0, 1, 1);
    cycle(0, 3'd0, 4'd0, '0, '0, 1, 1);
    chk("lit_rst_valid", out_valid, 1'b0);
    chk("lit_rst_ready", in_ready, 1'b1);
    chk("lit_rst_we0", out_we0, 1'b0);
    chk("lit_rst_data0", out_data0, '0);

    // ADD all-ones + 1 wraps to zero with carry.
    cycle(1, 3'd0, 4'd3, '1, 64'd1, 1, 0);
    chk("lit_add_valid", out_valid, 1'b1);
    chk("lit_add_data0", out_data0, 64'd0);
    chk("lit_add_idx0", out_idx0, 4'd3);
    chk("lit_add_zf", out_zf, 1'b1);
    chk("lit_add_cf", out_cf, 1'b1);
    chk("lit_add_fwe", out_fwe, 1'b1);
    cycle(0, 3'd0, 4'd0, '0, '0, 1, 0);

    // MUL 2^32 * 2^32 = 2^64; busy for 64 cycles, offers ignored meanwhile.
    cycle(1, 3'd6, 4'd9, 64'h1_0000_0000, 64'h1_0000_0000, 1, 0);
    for (int i = 1; i <= 64; i++) begin
      chk("lit_mul_busy", in_ready, 1'b0);
      chk("lit_mul_novalid", out_valid, 1'b0);
      cycle(1, 3'd0, 4'd1, rv(), rv(), 1'($urandom_range(0, 1)), 0);
    end
    chk("lit_mul_valid", out_valid, 1'b1);
    chk("lit_mul_data0", out_data0, 64'd0);
    chk("lit_mul_idx0", out_idx0, 4'd0);
    chk("lit_mul_data1", out_data1, 64'd1);
    chk("lit_mul_idx1", out_idx1, 4'd2);
    chk("lit_mul_cf", out_cf, 1'b1);
    chk("lit_mul_zf", out_zf, 1'b0);

    // SUB 5-7 accepted back-to-back, then stalled 5 cycles.
    cycle(1, 3'd1, 4'd4, 64'd5, 64'd7, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("lit_sub_valid", out_valid, 1'b1);
      chk("lit_sub_data0", out_data0, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("lit_sub_cf", out_cf, 1'b1);
      cycle(1, 3'd0, 4'd6, rv(), rv(), 0, 0);
    end
    cycle(1, 3'd5, 4'd5, 64'd123, 64'h42, 1, 0);
    chk("lit_mov_data0", out_data0, 64'h42);
    chk("lit_mov_fwe", out_fwe, 1'b0);
    chk("lit_mov_we0", out_we0, 1'b1);

    cycle(1, 3'd7, 4'd1, rv(), rv(), 1, 0);
    chk("lit_ret_valid", out_valid, 1'b1);
    chk("lit_ret_ret", out_ret, 1'b1);
    chk("lit_ret_we0", out_we0, 1'b0);
    chk("lit_ret_we1", out_we1, 1'b0);
    chk("lit_ret_fwe", out_fwe, 1'b0);

    // Reset in the middle of a multiply aborts it.
    cycle(1, 3'd6, 4'd1, rv(), rv(), 1, 0);
    for (int i = 0; i < 9; i++) cycle(0, 3'd0, 4'd0, '0, '0, 1, 0);
    cycle(1, 3'd0, 4'd1, 64'd1, 64'd1, 1, 1);
    chk("lit_abort_valid", out_valid, 1'b0);
    chk("lit_abort_ready", in_ready, 1'b1);
    chk("lit_abort_we0", out_we0, 1'b0);
    chk("lit_abort_we1", out_we1, 1'b0);
    chk("lit_abort_fwe", out_fwe, 1'b0);
    cycle(1, 3'd0, 4'd7, 64'd1, 64'd1, 1, 0);
    chk("lit_after_abort_data0", out_data0, 64'd2);
    chk("lit_after_abort_idx0", out_idx0, 4'd7);

    // Randomized traffic checked entirely against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 19);
      rop = (r == 19) ? 3'd6 : ((r % 8 == 6) ? 3'd0 : 3'(r % 8));
      cycle($urandom_range(0, 9) < 6, rop, 4'($urandom), rv(), rv(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
    end

    // 8-bit instance: multiply latency and results.
    e_reset = 1'b1;
    repeat (2) @(negedge clk);
    e_reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      ea = (t == 0) ? 8'hFF : 8'($urandom);
      eb = (t == 0) ? 8'hFF : 8'($urandom);
      ep = {8'd0, ea} * {8'd0, eb};
      e_in_valid = 1'b1; e_in_op = 3'd6; e_in_a = ea; e_in_b = eb; e_out_ready = 1'b1;
      #1;
      chk("w8_ready_idle", e_in_ready, 1'b1);
      @(negedge clk);
      e_in_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        chk("w8_novalid", e_out_valid, 1'b0);
        chk("w8_busy", e_in_ready, 1'b0);
        @(negedge clk);
      end
      chk("w8_valid", e_out_valid, 1'b1);
      chk("w8_data0", e_data0, ep[7:0]);
      chk("w8_data1", e_data1, ep[15:8]);
      chk("w8_cf", e_cf, ep[15:8] != 0);
      chk("w8_zf", e_zf, ep == 0);
      if (t == 0) begin
        chk("lit_w8_data0", e_data0, 8'h01);
        chk("lit_w8_data1", e_data1, 8'hFE);
        chk("lit_w8_cf", e_cf, 1'b1);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits (>=8).
REQ-002 SHALL have parameter NREGS, default 16, architectural register count; RW = clog2(NREGS).
REQ-003 SHALL have parameter LO_REG, default 0, destination index of multiply low half.
REQ-004 SHALL have parameter HI_REG, default 2, destination index of multiply high half.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  in  1  operation offered.
REQ-008 SHALL have port in_ready  out  1  operation accepted when in_valid & in_ready.
REQ-009 SHALL have port in_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 MUL, 7 RET.
REQ-010 SHALL have port in_dst  in  RW  destination register index.
REQ-011 SHALL have port in_a  in  WIDTH  first operand value (register or immediate, resolved upstream).
REQ-012 SHALL have port in_b  in  WIDTH  second operand value.
REQ-013 SHALL have port out_valid  out  1  result held; transferred when out_valid & out_ready.
REQ-014 SHALL have port out_ready  in  1  writeback consumer ready.
REQ-015 SHALL have ports out_we0 out 1, out_idx0 out RW, out_data0 out WIDTH  primary writeback.
REQ-016 SHALL have ports out_we1 out 1, out_idx1 out RW, out_data1 out WIDTH  secondary writeback (MUL high half).
REQ-017 SHALL have ports out_fwe out 1, out_zf out 1, out_cf out 1  flag write enable and values.
REQ-018 SHALL have port out_ret  out  1  result is a return; instruction stream terminates.

Function
REQ-019 SHALL implement FSM states IDLE, MUL, DONE; all outputs registered.
REQ-020 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready).
REQ-021 On accept of op 0-5 or 7, SHALL enter DONE next cycle with out_valid=1 (latency 1).
REQ-022 ADD: data0=a+b mod 2^WIDTH, cf=carry out; SUB: data0=a-b, cf=borrow (a<b unsigned); AND/OR/XOR bitwise, cf=0.
REQ-023 For ADD..XOR, out_we0=1, out_idx0=in_dst, out_fwe=1, out_zf=(data0==0), out_we1=0.
REQ-024 MOV: data0=b, out_we0=1, out_idx0=in_dst, out_fwe=0, out_we1=0.
REQ-025 MUL: unsigned WIDTHxWIDTH->2*WIDTH product via radix-2 shift-add, one partial-product step per cycle in state MUL, WIDTH steps.
REQ-026 MUL result SHALL raise out_valid exactly WIDTH+1 cycles after accept; in_ready=0 throughout MUL.
REQ-027 MUL: out_we0=1, idx0=LO_REG, data0=low half; out_we1=1, idx1=HI_REG, data1=high half; out_fwe=1, cf=(high!=0), zf=(product==0); in_dst ignored.
REQ-028 RET: out_ret=1, out_we0=out_we1=out_fwe=0; all other ops out_ret=0.
REQ-029 In DONE with out_ready=0, all out_* SHALL hold stable.
REQ-030 DONE with out_ready=1: if in_valid, accept new op same cycle (back-to-back, throughput 1/cycle for non-MUL); else go IDLE, out_valid=0.
REQ-031 Inputs SHALL be captured at accept; later changes on in_* SHALL not affect an in-flight op.
REQ-032 in_valid while in_ready=0 SHALL be ignored (no capture, no state change).

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE, out_valid=0, all out_* data/index/enable/flag outputs 0, multiply counter and accumulators 0.
REQ-034 reset during MUL or DONE SHALL abort the operation with no writeback; in_ready=1 the cycle after reset deasserts... the cycle after the reset edge.
REQ-035 reset SHALL take priority over a simultaneous accept.

Verification
REQ-036 ADD a=all-ones, b=1, dst=3 -> one cycle later out_valid=1, data0=0, idx0=3, zf=1, cf=1, fwe=1.
REQ-037 MUL (WIDTH=64) a=2^32, b=2^32 -> out_valid at accept+65, data0=0 idx0=0, data1=1 idx1=2, cf=1, zf=0; in_ready=0 cycles 1-64.
REQ-038 SUB a=5, b=7 with out_ready=0 for 5 cycles -> data0=0xFFFF_FFFF_FFFF_FFFE, cf=1 stable all 5 cycles, in_ready=0; then out_ready=1 with in_valid MOV b=0x42 -> accepted same cycle, next cycle data0=0x42, fwe=0.
REQ-039 reset asserted at MUL cycle 10 -> next cycle out_valid=0, in_ready=1, all we=0; following ADD 1+1 yields data0=2 normally.
REQ-040 RET -> out_valid=1, out_ret=1, we0=we1=fwe=0.
REQ-041 WIDTH=8 instance: MUL 0xFF*0xFF -> data0=0x01, data1=0xFE, cf=1, out_valid at accept+9.
